// File: rtl/cm3_arb_pkg.sv
// Shared AHB encodings, beat counter sizing and FSM states for cm3 output-stage arbiters.
package cm3_arb_pkg;

  localparam int unsigned BEAT_CNT_W = 4;
  localparam int unsigned HTRANS_W   = 2;
  localparam int unsigned HBURST_W   = 3;

  localparam logic [HTRANS_W-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [HTRANS_W-1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [HTRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [HTRANS_W-1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [HBURST_W-1:0] HBURST_SINGLE = 3'b000;
  localparam logic [HBURST_W-1:0] HBURST_INCR   = 3'b001;
  localparam logic [HBURST_W-1:0] HBURST_WRAP4  = 3'b010;
  localparam logic [HBURST_W-1:0] HBURST_INCR4  = 3'b011;
  localparam logic [HBURST_W-1:0] HBURST_WRAP8  = 3'b100;
  localparam logic [HBURST_W-1:0] HBURST_INCR8  = 3'b101;
  localparam logic [HBURST_W-1:0] HBURST_WRAP16 = 3'b110;
  localparam logic [HBURST_W-1:0] HBURST_INCR16 = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Beats remaining after the NONSEQ beat of a fixed-length burst; 0 for SINGLE/INCR.
  function automatic logic [BEAT_CNT_W-1:0] beats_for_burst(input logic [HBURST_W-1:0] hburst);
    logic [BEAT_CNT_W-1:0] beats;
    beats = '0;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
      default:                      beats = '0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/cm3_rr_pick.sv
// Combinational round-robin picker: rotate past last_grant, priority-encode, un-rotate.
module cm3_rr_pick #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned PORT_IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0]  req,
  input  logic [PORT_IDX_W-1:0] last_grant,
  output logic [PORT_IDX_W-1:0] winner,
  output logic                  any_req
);

  logic [NUM_PORTS-1:0] rot;
  logic                 found;
  int unsigned          off;
  int unsigned          idx;

  always_comb begin
    rot   = '0;
    found = 1'b0;
    off   = 0;
    idx   = 0;
    // rot[0] is the port just after last_grant
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = (32'(last_grant) + 32'd1 + i) % NUM_PORTS;
      rot[PORT_IDX_W'(i)] = req[PORT_IDX_W'(idx)];
    end
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!found && rot[PORT_IDX_W'(i)]) begin
        found = 1'b1;
        off   = i;
      end
    end
    winner  = PORT_IDX_W'((32'(last_grant) + 32'd1 + off) % NUM_PORTS);
    any_req = |req;
  end

endmodule

// File: rtl/cm3_burst_rr_arb.sv
// Burst- and lock-aware round-robin arbiter selecting which input port drives the shared slave.
module cm3_burst_rr_arb
  import cm3_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned PORT_IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [NUM_PORTS-1:0]  req,
  input  logic                  HREADYM,
  input  logic                  HSELM,
  input  logic [HTRANS_W-1:0]   HTRANSM,
  input  logic [HBURST_W-1:0]   HBURSTM,
  input  logic                  HMASTLOCKM,
  output logic [PORT_IDX_W-1:0] addr_in_port,
  output logic                  no_port
);

  arb_state_t              state, state_nxt;
  logic [PORT_IDX_W-1:0]   addr_nxt;
  logic                    no_port_nxt;
  logic [PORT_IDX_W-1:0]   last_grant, last_grant_nxt;
  logic [BEAT_CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic                    hold;
  logic [PORT_IDX_W-1:0]   winner;
  logic                    any_req;

  cm3_rr_pick #(
    .NUM_PORTS  (NUM_PORTS),
    .PORT_IDX_W (PORT_IDX_W)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .winner     (winner),
    .any_req    (any_req)
  );

  // State and registered outputs; everything freezes while the slave stalls.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state        <= ST_IDLE;
      addr_in_port <= '0;
      no_port      <= 1'b1;
      last_grant   <= PORT_IDX_W'(NUM_PORTS - 1);
      beat_cnt     <= '0;
    end else if (HREADYM) begin
      state        <= state_nxt;
      addr_in_port <= addr_nxt;
      no_port      <= no_port_nxt;
      last_grant   <= last_grant_nxt;
      beat_cnt     <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr_in_port;
    no_port_nxt    = no_port;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    hold           = 1'b0;

    // Remaining-beat tracking; IDLE or deselect ends a burst early
    if (!HSELM || HTRANSM == HTRANS_IDLE) begin
      beat_cnt_nxt = '0;
    end else if (HTRANSM == HTRANS_NONSEQ) begin
      beat_cnt_nxt = beats_for_burst(HBURSTM);
    end else if (HTRANSM == HTRANS_SEQ) begin
      beat_cnt_nxt = (beat_cnt != '0) ? beat_cnt - 4'd1 : '0;
    end

    hold = HMASTLOCKM | (beat_cnt_nxt != '0) | ((HTRANSM == HTRANS_BUSY) & HSELM);

    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nxt      = ST_GRANT;
          addr_nxt       = winner;
          no_port_nxt    = 1'b0;
          last_grant_nxt = winner;
        end
      end
      ST_GRANT: begin
        if (!hold) begin
          if (any_req) begin
            addr_nxt       = winner;
            last_grant_nxt = winner;
          end else begin
            state_nxt   = ST_IDLE;
            no_port_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        no_port_nxt = 1'b1;
      end
    endcase
  end

  a_port_in_range : assert property (@(posedge HCLK) disable iff (!HRESETn)
    32'(addr_in_port) < NUM_PORTS);

endmodule

// File: tb/tb_cm3_burst_rr_arb.sv
// Scoreboard bench for cm3_burst_rr_arb: expected grants queued with each stimulus beat.
module tb_cm3_burst_rr_arb;
  import cm3_arb_pkg::*;

  localparam int unsigned NUM_PORTS  = 4;
  localparam int unsigned PORT_IDX_W = 2;

  logic                  HCLK;
  logic                  HRESETn;
  logic [NUM_PORTS-1:0]  req;
  logic                  HREADYM;
  logic                  HSELM;
  logic [1:0]            HTRANSM;
  logic [2:0]            HBURSTM;
  logic                  HMASTLOCKM;
  logic [PORT_IDX_W-1:0] addr_in_port;
  logic                  no_port;

  int unsigned n_checks;
  int unsigned n_errors;

  logic [2:0] exp_q[$];
  string      tag_q[$];

  cm3_burst_rr_arb #(
    .NUM_PORTS  (NUM_PORTS),
    .PORT_IDX_W (PORT_IDX_W)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req          (req),
    .HREADYM      (HREADYM),
    .HSELM        (HSELM),
    .HTRANSM      (HTRANSM),
    .HBURSTM      (HBURSTM),
    .HMASTLOCKM   (HMASTLOCKM),
    .addr_in_port (addr_in_port),
    .no_port      (no_port)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare current outputs against the oldest queued expectation {addr, no_port}.
  task automatic sb_pop();
    logic [2:0] e;
    string      t;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq({t, ".port"}, 32'(addr_in_port), 32'(e[2:1]));
      check_eq({t, ".noport"}, 32'(no_port), 32'(e[0]));
    end
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge outputs, then compare.
  task automatic step(input string tag, input logic [3:0] r, input logic rdy, input logic sel,
                      input logic [1:0] trans, input logic [2:0] burst, input logic lock,
                      input logic [1:0] exp_port, input logic exp_nop);
    req        = r;
    HREADYM    = rdy;
    HSELM      = sel;
    HTRANSM    = trans;
    HBURSTM    = burst;
    HMASTLOCKM = lock;
    exp_q.push_back({exp_port, exp_nop});
    tag_q.push_back(tag);
    @(posedge HCLK);
    #1;
    sb_pop();
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    HRESETn    = 1'b0;
    req        = '0;
    HREADYM    = 1'b1;
    HSELM      = 1'b0;
    HTRANSM    = HTRANS_IDLE;
    HBURSTM    = HBURST_SINGLE;
    HMASTLOCKM = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    exp_q.push_back({2'd0, 1'b1});
    tag_q.push_back("reset");
    sb_pop();
    #2 HRESETn = 1'b1;

    // Basic round robin after reset
    step("rr_first",  4'b0110, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 2'd1, 0);
    step("rr_single", 4'b0110, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, 2'd2, 0);
    step("rr_park",   4'b0000, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 2'd2, 1);

    // INCR4 on port 0 with a BUSY mid-burst
    step("b4_grant",  4'b0001, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 2'd0, 0);
    step("b4_ns",     4'b1111, 1, 1, HTRANS_NONSEQ, HBURST_INCR4,  0, 2'd0, 0);
    step("b4_seq1",   4'b1111, 1, 1, HTRANS_SEQ,    HBURST_INCR4,  0, 2'd0, 0);
    step("b4_busy",   4'b1111, 1, 1, HTRANS_BUSY,   HBURST_INCR4,  0, 2'd0, 0);
    step("b4_seq2",   4'b1111, 1, 1, HTRANS_SEQ,    HBURST_INCR4,  0, 2'd0, 0);
    step("b4_seq3",   4'b1111, 1, 1, HTRANS_SEQ,    HBURST_INCR4,  0, 2'd1, 0);

    // Locked SINGLEs on port 3, request dropped while locked
    step("lk_grant",  4'b1000, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 2'd3, 0);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("lk_single%0d", i), (i < 2) ? 4'b1111 : 4'b0111, 1, 1,
           HTRANS_NONSEQ, HBURST_SINGLE, 1, 2'd3, 0);
    end
    step("lk_release", 4'b0111, 1, 1, HTRANS_IDLE,  HBURST_SINGLE, 0, 2'd0, 0);

    // Stall: nothing moves while HREADYM is low
    step("st_pre",    4'b0001, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 2'd0, 0);
    for (int i = 0; i < 6; i++) begin
      step($sformatf("st_hold%0d", i), (i < 3) ? 4'b0001 : 4'b1000, 0, 0,
           HTRANS_IDLE, HBURST_SINGLE, 0, 2'd0, 0);
    end
    step("st_apply",  4'b1000, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 2'd3, 0);

    // INCR8 on port 2 ended early by IDLE
    step("b8_grant",  4'b0100, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 2'd2, 0);
    step("b8_ns",     4'b1111, 1, 1, HTRANS_NONSEQ, HBURST_INCR8,  0, 2'd2, 0);
    step("b8_seq1",   4'b1111, 1, 1, HTRANS_SEQ,    HBURST_INCR8,  0, 2'd2, 0);
    step("b8_seq2",   4'b1111, 1, 1, HTRANS_SEQ,    HBURST_INCR8,  0, 2'd2, 0);
    step("b8_term",   4'b0000, 1, 1, HTRANS_IDLE,   HBURST_INCR8,  0, 2'd2, 1);
    step("idle_lock", 4'b0000, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 2'd2, 1);

    // INCR16 on port 1, reset asserted at beat_cnt=9
    step("b16_grant", 4'b0010, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 2'd1, 0);
    step("b16_ns",    4'b1111, 1, 1, HTRANS_NONSEQ, HBURST_INCR16, 1, 2'd1, 0);
    for (int i = 0; i < 6; i++) begin
      step($sformatf("b16_seq%0d", i), 4'b1111, 1, 1, HTRANS_SEQ, HBURST_INCR16, 1,
           2'd1, 0);
    end
    #2 HRESETn = 1'b0;
    #1;
    exp_q.push_back({2'd0, 1'b1});
    tag_q.push_back("async_rst");
    sb_pop();
    HMASTLOCKM = 1'b0;
    #3 HRESETn = 1'b1;
    step("post_rst",  4'b1000, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 2'd3, 0);
    step("post_seq",  4'b0100, 1, 1, HTRANS_SEQ,    HBURST_INCR16, 0, 2'd2, 0);

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
